// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and digit helpers for the serial BCD adder/subtractor.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Nine's complement of one digit, wrapping mod 16 for non-BCD nibbles.
  function automatic logic [3:0] nines_comp(input logic [3:0] digit);
    return BCD_MAX - digit;
  endfunction

endpackage

// File: rtl/bcd_serial_addsub_if.sv
// Operand/result bundle between the BCD operand registers and the serial adder.
interface bcd_serial_addsub_if #(
  parameter int DIGITS = 4
);

  logic                  start;
  logic                  sub;
  logic                  carry_in;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   sum;
  logic                  carry_out;
  logic                  err;

  modport master (
    output start, sub, carry_in, a, b,
    input  busy, done, sum, carry_out, err
  );

  modport slave (
    input  start, sub, carry_in, a, b,
    output busy, done, sum, carry_out, err
  );

endinterface

// File: rtl/bcd_serial_addsub_digit_add.sv
// One decimal digit slice: binary add plus +6 correction when the raw sum exceeds 9.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] d,
  output logic       cout
);

  logic [4:0] t_s;

  // Raw 5-bit sum, then decimal correction; invalid digits follow the same rule.
  always_comb begin
    t_s  = {1'b0, x} + {1'b0, y} + {4'd0, cin};
    d    = t_s[3:0];
    cout = 1'b0;
    if (t_s > {1'b0, BCD_MAX}) begin
      d    = t_s[3:0] + BCD_CORR;
      cout = 1'b1;
    end else begin
      d    = t_s[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Multi-digit packed-BCD adder/subtractor, one digit per clock, LSD first.
// Subtraction is a + nines(b) + 1; carry_out=1 then means no borrow.
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter  int DIGITS = 4,
  localparam int CW     = $clog2(DIGITS) + 1
) (
  input  logic                clk,
  input  logic                rst,
  bcd_serial_addsub_if.slave  bus
);

  localparam int             W    = 4 * DIGITS;
  localparam logic [CW-1:0]  LAST = CW'(DIGITS - 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           c_q, c_d;
  logic [W-1:0]   res_q, res_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
  logic           err_q, err_d;

  logic [W-1:0]   b_lat_s;
  logic           bad_s;
  logic [3:0]     dig_x_s;
  logic [3:0]     dig_y_s;
  logic [3:0]     dig_d_s;
  logic           dig_cout_s;

  // Operand B as it will be latched (nine's complemented in subtract mode) and the non-BCD flag.
  always_comb begin
    b_lat_s = bus.b;
    bad_s   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.sub) begin
        b_lat_s[4*i +: 4] = nines_comp(bus.b[4*i +: 4]);
      end else begin
        b_lat_s[4*i +: 4] = bus.b[4*i +: 4];
      end
      if ((bus.a[4*i +: 4] > BCD_MAX) || (bus.b[4*i +: 4] > BCD_MAX)) begin
        bad_s = 1'b1;
      end else begin
        bad_s = bad_s;
      end
    end
  end

  // Select the current digit pair for the shared correction slice.
  always_comb begin
    dig_x_s = a_q[{cnt_q, 2'b00} +: 4];
    dig_y_s = b_q[{cnt_q, 2'b00} +: 4];
  end

  bcd_digit_add u_digit (
    .x    (dig_x_s),
    .y    (dig_y_s),
    .cin  (c_q),
    .d    (dig_d_s),
    .cout (dig_cout_s)
  );

  // Next-state and registered-output logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = b_lat_s;
          c_d     = bus.sub ? 1'b1 : bus.carry_in;
          err_d   = bad_s;
          cnt_d   = '0;
          res_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        res_d[{cnt_q, 2'b00} +: 4] = dig_d_s;
        c_d   = dig_cout_s;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          sum_d   = res_d;
          cout_d  = dig_cout_s;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset discarding any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Self-checking bench: directed and random operations against a decimal-arithmetic model.
module tb_bcd_serial_addsub;

  localparam int D = 4;

  logic clk;
  logic rst;
  int   tests_run;
  int   fail_cnt;
  logic [15:0] prev_sum;

  bcd_serial_addsub_if #(.DIGITS(4)) bus4 ();
  bcd_serial_addsub_if #(.DIGITS(1)) bus1 ();

  bcd_serial_addsub #(.DIGITS(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
  bcd_serial_addsub #(.DIGITS(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r = 16'h0000;
    int x = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Reference: plain decimal arithmetic for valid operands, digit rule for invalid ones.
  task automatic ref_op(input logic [15:0] a, input logic [15:0] b, input logic s, input logic ci,
                        output logic [15:0] sum, output logic co, output logic er);
    int r;
    int c;
    int t;
    int y;
    er = 1'b0;
    for (int i = 0; i < D; i++)
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) er = 1'b1;
    if (!er) begin
      if (!s) r = bcd2int(a) + bcd2int(b) + int'(ci);
      else    r = bcd2int(a) - bcd2int(b) + 10000;
      co  = (r >= 10000);
      sum = int2bcd(r % 10000);
    end else begin
      c = s ? 1 : int'(ci);
      for (int i = 0; i < D; i++) begin
        y = s ? ((9 - int'(b[4*i +: 4])) & 15) : int'(b[4*i +: 4]);
        t = int'(a[4*i +: 4]) + y + c;
        if (t > 9) begin sum[4*i +: 4] = 4'((t + 6) & 15); c = 1; end
        else       begin sum[4*i +: 4] = 4'(t);            c = 0; end
      end
      co = c[0];
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic ci, input bit disturb);
    logic [15:0] es;
    logic        eco;
    logic        eer;
    int          n;
    int          busy_n;
    ref_op(a, b, s, ci, es, eco, eer);
    @(negedge clk);
    bus4.a = a; bus4.b = b; bus4.sub = s; bus4.carry_in = ci; bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    n = 0;
    busy_n = 0;
    check_eq("err_early", 32'(bus4.err), 32'(eer));
    while (!bus4.done && n < D + 4) begin
      if (bus4.busy) busy_n++;
      check_eq("sum_hold_run", 32'(bus4.sum), 32'(prev_sum));
      if (disturb && n == 1) begin
        bus4.start = 1'b1; bus4.a = 16'($urandom); bus4.b = 16'($urandom); bus4.sub = ~s;
      end else if (disturb && n == 2) begin
        bus4.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus4.start = 1'b0;
    if (bus4.busy) busy_n++;
    check_eq("done_latency", 32'(n), 32'(D));
    check_eq("sum", 32'(bus4.sum), 32'(es));
    check_eq("carry_out", 32'(bus4.carry_out), 32'(eco));
    check_eq("err", 32'(bus4.err), 32'(eer));
    @(negedge clk);
    check_eq("done_pulse_len", 32'(bus4.done), 32'd0);
    check_eq("busy_after", 32'(bus4.busy), 32'd0);
    check_eq("busy_cycles", 32'(busy_n), 32'(D + 1));
    check_eq("sum_hold_idle", 32'(bus4.sum), 32'(es));
    prev_sum = es;
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int i = 0; i < D; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  initial begin
    int n;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [3:0]  x1;
    logic [3:0]  y1;
    logic        s1;
    logic        c1;
    int          r1;
    tests_run = 0;
    fail_cnt  = 0;
    prev_sum  = 16'h0000;
    bus4.start = 1'b0; bus4.sub = 1'b0; bus4.carry_in = 1'b0; bus4.a = 16'h0; bus4.b = 16'h0;
    bus1.start = 1'b0; bus1.sub = 1'b0; bus1.carry_in = 1'b0; bus1.a = 4'h0;  bus1.b = 4'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(bus4.busy), 32'd0);
    check_eq("rst_done", 32'(bus4.done), 32'd0);
    check_eq("rst_sum", 32'(bus4.sum), 32'd0);
    check_eq("rst_cout", 32'(bus4.carry_out), 32'd0);
    check_eq("rst_err", 32'(bus4.err), 32'd0);
    rst = 1'b0;

    // Directed cases.
    run_op(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0);
    run_op(16'h9999, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    run_op(16'h5000, 16'h1234, 1'b1, 1'b0, 1'b0);
    run_op(16'h1234, 16'h5000, 1'b1, 1'b0, 1'b0);
    run_op(16'h5000, 16'h1234, 1'b1, 1'b1, 1'b0);
    run_op(16'h1234, 16'h5000, 1'b1, 1'b1, 1'b0);
    run_op(16'h00A0, 16'h0000, 1'b0, 1'b0, 1'b0);
    run_op(16'h0042, 16'h0017, 1'b0, 1'b0, 1'b0);
    run_op(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b1);

    // Reset on the second RUN cycle discards the operation.
    @(negedge clk);
    bus4.a = 16'h1234; bus4.b = 16'h5678; bus4.sub = 1'b0; bus4.carry_in = 1'b0; bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_busy", 32'(bus4.busy), 32'd0);
    check_eq("mid_rst_sum", 32'(bus4.sum), 32'd0);
    check_eq("mid_rst_cout", 32'(bus4.carry_out), 32'd0);
    check_eq("mid_rst_done", 32'(bus4.done), 32'd0);
    for (int i = 0; i < D + 2; i++) begin
      @(negedge clk);
      check_eq("no_done_after_rst", 32'(bus4.done), 32'd0);
    end
    prev_sum = 16'h0000;

    // Random operations, some with a non-BCD nibble, some disturbed mid-RUN.
    for (int k = 0; k < 40; k++) begin
      ra = rand_bcd();
      rb = rand_bcd();
      if ($urandom_range(0, 7) == 0) ra[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 7) == 0) rb[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    // Single-digit build: directed corner then random valid digits.
    for (int k = 0; k < 12; k++) begin
      if (k == 0) begin x1 = 4'h9; y1 = 4'h9; s1 = 1'b0; c1 = 1'b1; end
      else begin
        x1 = 4'($urandom_range(0, 9)); y1 = 4'($urandom_range(0, 9));
        s1 = 1'($urandom_range(0, 1)); c1 = 1'($urandom_range(0, 1));
      end
      r1 = s1 ? (int'(x1) - int'(y1) + 10) : (int'(x1) + int'(y1) + int'(c1));
      @(negedge clk);
      bus1.a = x1; bus1.b = y1; bus1.sub = s1; bus1.carry_in = c1; bus1.start = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      n = 0;
      while (!bus1.done && n < 6) begin
        @(negedge clk);
        n++;
      end
      check_eq("d1_latency", 32'(n), 32'd1);
      check_eq("d1_sum", 32'(bus1.sum), 32'(r1 % 10));
      check_eq("d1_cout", 32'(bus1.carry_out), 32'(r1 >= 10));
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
